// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: default operand width,
// FSM state encoding and bit-counter width.
package serial_sub_pkg;

    localparam int SUB_WIDTH = 8;
    localparam int SUB_CNT_W = $clog2(SUB_WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } sub_state_e;

endpackage

// File: rtl/serial_sub_8_full_sub.sv
// Gate-level single-bit full subtractor: diff = x - y - bi, bo = borrow out.
module full_sub (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic diff,
    output logic bo
);

    logic w_xy;
    logic w_brw_gen;
    logic w_brw_prop;

    assign w_xy       = x ^ y;
    assign w_brw_gen  = ~x & y;
    assign w_brw_prop = ~w_xy & bi;
    assign diff       = w_xy ^ bi;
    assign bo         = w_brw_gen | w_brw_prop;

endmodule

// File: rtl/serial_sub_8.sv
// Bit-serial subtractor D = A - B - bin, one bit per clock, LSB first.
// Handshake: start is accepted in IDLE or DONE; busy is high for the WIDTH
// processing cycles; done pulses for one cycle with d/bout valid, and d/bout
// hold until the next result completes.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
// dbg_state exposes the FSM state for observation.
module serial_sub_8
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] ST_IDLE = S_IDLE;
    localparam logic [1:0] ST_RUN  = S_RUN;
    localparam logic [1:0] ST_DONE = S_DONE;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_br;
    logic [WIDTH-2:0] r_res;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;
    logic             w_bo;
    logic             w_accept;
`ifdef SERIAL_SUB_OVF_EN
    logic             r_a_msb;
    logic             r_b_msb;
`endif

    full_sub u_cell (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .bi   (r_br),
        .diff (w_diff),
        .bo   (w_bo)
    );

    // A new operation may begin from IDLE or directly from DONE.
    assign w_accept  = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign dbg_state = r_state;

    // FSM, operand shifting, result assembly and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_br    <= 1'b0;
            r_res   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            d       <= '0;
            bout    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            ovf     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (w_accept) begin
                r_state <= ST_RUN;
                r_a     <= a;
                r_b     <= b;
                r_br    <= bin;
                r_cnt   <= '0;
                busy    <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                r_a_msb <= a[WIDTH-1];
                r_b_msb <= b[WIDTH-1];
`endif
            end else if (r_state == ST_RUN) begin
                r_a   <= r_a >> 1;
                r_b   <= r_b >> 1;
                r_br  <= w_bo;
                r_res <= {w_diff, r_res[WIDTH-2:1]};
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == LAST_BIT) begin
                    // The bit just computed is the MSB; publish the result.
                    r_state <= ST_DONE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    d       <= {w_diff, r_res};
                    bout    <= w_bo;
`ifdef SERIAL_SUB_OVF_EN
                    ovf     <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_diff);
`endif
                end
            end else if (r_state == ST_DONE) begin
                r_state <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_serial_sub_8.sv
// Self-checking bench for serial_sub_8 (define SERIAL_SUB_OVF_EN to cover ovf).
// Handshake under test: start sampled at a rising edge in IDLE/DONE is
// accepted; busy then stays high WIDTH cycles and done pulses once after.
module tb_serial_sub_8;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf_obs;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic         exp_bo_q[$];
    logic         exp_ov_q[$];

    serial_sub_8 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .busy      (busy),
        .done      (done),
        .d         (d),
        .bout      (bout),
`ifdef SERIAL_SUB_OVF_EN
        .ovf       (ovf_obs),
`endif
        .dbg_state (dbg_state)
    );

`ifndef SERIAL_SUB_OVF_EN
    assign ovf_obs = 1'b0;
`endif

    // clock / reset
    always #5 clk = ~clk;

    // reference model: plain integer arithmetic
    function automatic logic [W-1:0] model_d(input int unsigned ma, input int unsigned mb, input int unsigned mbin);
        int unsigned full;
        full = (ma + 256 - mb - mbin) % 256;
        return full[W-1:0];
    endfunction

    function automatic logic model_bout(input int unsigned ma, input int unsigned mb, input int unsigned mbin);
        return ma < (mb + mbin);
    endfunction

    function automatic logic model_ovf(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic [W-1:0] md);
        return (ma[W-1] ^ mb[W-1]) & (ma[W-1] ^ md[W-1]);
    endfunction

    // driver: one operation, returns observed result, done latency and busy count
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                          output logic [W-1:0] od, output logic obo, output logic oov,
                          output int lat, output int bcnt);
        int n;
        @(negedge clk);
        start = 1'b1; a = ia; b = ib; bin = ibin;
        @(negedge clk);
        start = 1'b0;
        lat = -1; bcnt = 0; n = 1;
        while (n <= 30) begin
            if (busy) bcnt++;
            if (done) begin
                lat = n;
                break;
            end
            @(negedge clk);
            n++;
        end
        od = d; obo = bout; oov = ovf_obs;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, d, bout, ovf_obs} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%0b done=%0b d=%h bout=%0b ovf=%0b want all 0",
                     busy, done, d, bout, ovf_obs);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] va[4] = '{8'h50, 8'h00, 8'h10, 8'h80};
        logic [W-1:0] vb[4] = '{8'h20, 8'h01, 8'h0F, 8'h01};
        logic         vc[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] od;
        logic         obo, oov;
        int           lat, bcnt;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(model_d(va[i], vb[i], vc[i]));
            exp_bo_q.push_back(model_bout(va[i], vb[i], vc[i]));
            exp_ov_q.push_back(model_ovf(va[i], vb[i], model_d(va[i], vb[i], vc[i])));
            run_op(va[i], vb[i], vc[i], od, obo, oov, lat, bcnt);
            checks++;
            if (lat !== 9 || bcnt !== 8) begin
                errors++;
                $display("FAIL directed_timing[%0d] got done_at=%0d busy_cycles=%0d want 9 and 8", i, lat, bcnt);
            end
            checks++;
            if (od !== exp_q[0] || obo !== exp_bo_q[0]) begin
                errors++;
                $display("FAIL directed_result[%0d] got d=%h bout=%0b want d=%h bout=%0b",
                         i, od, obo, exp_q[0], exp_bo_q[0]);
            end
`ifdef SERIAL_SUB_OVF_EN
            checks++;
            if (oov !== exp_ov_q[0]) begin
                errors++;
                $display("FAIL directed_ovf[%0d] got %0b want %0b", i, oov, exp_ov_q[0]);
            end
`endif
            void'(exp_q.pop_front()); void'(exp_bo_q.pop_front()); void'(exp_ov_q.pop_front());
        end
        // done must be a single-cycle pulse
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_width got done=%0b one cycle later want 0", done);
        end
    endtask

    task automatic test_ignore_start();
        int pulses = 0;
        @(negedge clk);
        start = 1'b1; a = 8'h50; b = 8'h20; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 8'h05; b = 8'h03;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (done) begin
                pulses++;
                checks++;
                if (d !== 8'h30 || bout !== 1'b0) begin
                    errors++;
                    $display("FAIL ignore_start_result got d=%h bout=%0b want d=30 bout=0", d, bout);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL ignore_start_pulses got %0d want 1", pulses);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        int busy_seen = 0;
        logic [W-1:0] od;
        logic         obo, oov;
        int           lat, bcnt;
        @(negedge clk);
        start = 1'b1; a = 8'h50; b = 8'h20; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, d, bout, ovf_obs} !== '0) begin
            errors++;
            $display("FAIL reset_mid_async got busy=%0b done=%0b d=%h bout=%0b ovf=%0b want all 0",
                     busy, done, d, bout, ovf_obs);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) pulses++;
            if (busy) busy_seen++;
            @(negedge clk);
        end
        checks++;
        if (pulses !== 0 || busy_seen !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_done got done_pulses=%0d busy_cycles=%0d want 0 and 0", pulses, busy_seen);
        end
        run_op(8'h10, 8'h0F, 1'b1, od, obo, oov, lat, bcnt);
        checks++;
        if (lat !== 9 || od !== 8'h00 || obo !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_recover got done_at=%0d d=%h bout=%0b want 9 d=00 bout=0", lat, od, obo);
        end
    endtask

    task automatic test_back_to_back();
        int done_at[$];
        int n;
        logic [W-1:0] d_first;
        @(negedge clk);
        start = 1'b1; a = 8'h50; b = 8'h20; bin = 1'b0;
        @(negedge clk);
        a = 8'h03; b = 8'h05;
        d_first = 'x;
        for (n = 1; n <= 30; n++) begin
            if (n == 10) start = 1'b0;
            if (done) begin
                done_at.push_back(n);
                if (done_at.size() == 1) d_first = d;
                if (done_at.size() == 2) begin
                    checks++;
                    if (d !== 8'hFE || bout !== 1'b1) begin
                        errors++;
                        $display("FAIL b2b_second_result got d=%h bout=%0b want d=fe bout=1", d, bout);
                    end
                end
            end
            if (n == 10) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_no_idle got busy=%0b at cycle 10 want 1", busy);
                end
            end
            if (n == 14) begin
                checks++;
                if (d !== 8'h30) begin
                    errors++;
                    $display("FAIL b2b_hold_d got d=%h during second run want 30", d);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (done_at.size() != 2 || done_at[0] != 9 || done_at[1] != 18 || d_first !== 8'h30) begin
            errors++;
            $display("FAIL b2b_timing got pulses=%0d first=%0d second=%0d d1=%h want 2 9 18 30",
                     done_at.size(), (done_at.size() > 0) ? done_at[0] : -1,
                     (done_at.size() > 1) ? done_at[1] : -1, d_first);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W-1:0] od;
        logic         obo, oov;
        int           lat, bcnt;
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            exp_q.push_back(model_d(ra, rb, rc));
            exp_bo_q.push_back(model_bout(ra, rb, rc));
            exp_ov_q.push_back(model_ovf(ra, rb, model_d(ra, rb, rc)));
            run_op(ra, rb, rc, od, obo, oov, lat, bcnt);
            checks++;
            if (lat !== 9 || od !== exp_q[0] || obo !== exp_bo_q[0]) begin
                errors++;
                $display("FAIL random[%0d] a=%h b=%h bin=%0b got d=%h bout=%0b done_at=%0d want d=%h bout=%0b done_at=9",
                         i, ra, rb, rc, od, obo, lat, exp_q[0], exp_bo_q[0]);
            end
`ifdef SERIAL_SUB_OVF_EN
            checks++;
            if (oov !== exp_ov_q[0]) begin
                errors++;
                $display("FAIL random_ovf[%0d] got %0b want %0b", i, oov, exp_ov_q[0]);
            end
`endif
            void'(exp_q.pop_front()); void'(exp_bo_q.pop_front()); void'(exp_ov_q.pop_front());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
